apb_mem_arbiter: RTL and testbench
==================================

# apb_mem_arbiter

Two-port arbiter and APB master that shares the single APB memory bus between the core's instruction-fetch path and its load/store path. Each requester issues a held request and receives a one-cycle completion pulse; the arbiter serialises the requests into APB SETUP/ACCESS transfers. It applies round-robin fairness, a ready timeout, and error reporting. It sits between the multicycle control FSM and the APB interconnect, and supplies the `mem_ready` the FSM waits on.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` strobe bits
- `TIMEOUT`, 255, maximum ACCESS cycles without `pready` before abort; 0 disables the timeout
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset: synchronous, active-high
- `if_req`  in  1  fetch request, held until `if_ready`
- `if_addr`  in  ADDR_W  fetch address
- `if_ready`  out  1  one-cycle fetch completion pulse
- `if_rdata`  out  DATA_W  fetch data, valid with `if_ready`
- `if_err`  out  1  fetch error, valid with `if_ready`
- `d_req`  in  1  data request, held until `d_ready`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_be`  in  DATA_W/8  byte enables for writes
- `d_ready`  out  1  one-cycle data completion pulse
- `d_rdata`  out  DATA_W  load data, valid with `d_ready`
- `d_err`  out  1  data error, valid with `d_ready`
- `psel`, `penable`, `pwrite`  out  1  APB control
- `paddr`  out  ADDR_W  APB address
- `pwdata`  out  DATA_W  APB write data
- `pstrb`  out  DATA_W/8  APB write strobes
- `prdata`  in  DATA_W  APB read data
- `pready`  in  1  APB ready
- `pslverr`  in  1  APB slave error
- `busy`  out  1  high in every state except IDLE
- `owner`  out  1  current or most recent grant: 0 = fetch, 1 = data

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- **IDLE**
  - `psel` and `penable` are 0.
  - If any request is present, grant it and go to SETUP.
  - Latch into registers: address, `pwrite`, `pwdata`, `pstrb`, and `owner`.
- **Arbitration** (IDLE only)
  - Single requester: that requester is granted.
  - Both requesting: grant the port opposite to `last_owner`.
  - `last_owner` resets to 0 (fetch), so data wins the first tie.
- **Fetch grant**: `pwrite`=0, `pstrb`=0, `pwdata`=0.
- **Data grant**: `pwrite`=`d_we`. `pstrb`=`d_be` if write, else 0. `pwdata`=`d_wdata`.
- **SETUP**: `psel`=1, `penable`=0. Always exactly one cycle, then ACCESS.
- **ACCESS**
  - `psel`=1, `penable`=1; a wait counter increments each cycle.
  - On `pready`=1:
    - Capture `prdata` into the owner's rdata register (forced to 0 if `pslverr`).
    - Capture `pslverr` into the owner's err register.
    - Go to DONE.
  - On timeout (`TIMEOUT`≠0, counter reaches `TIMEOUT` with `pready`=0):
    - Abort; err=1, rdata=0; go to DONE.
- **DONE**
  - `psel`=0, `penable`=0.
  - The owner's ready pulse is high for this cycle only.
  - Update `last_owner`, then go to IDLE.
- Request inputs, `d_we`, address, data and strobes are ignored outside IDLE. Deasserting a request mid-transfer does not cancel it.
- APB outputs are registered and stay stable from SETUP through the final ACCESS cycle.
- rdata and err registers hold their value until the next completion for the same port.
- Address alignment is not checked; the address passes through unmodified.

## Timing
- Reset value of every output is 0; `last_owner`=0, wait counter=0, state=IDLE.
- Reset asserted in any state, including mid-ACCESS: IDLE on the next edge with `psel`/`penable` low. The pending transfer is dropped and no ready pulse is issued.
- Latency, request sampled in IDLE at cycle N with zero-wait slave:
  - SETUP at N+1, ACCESS at N+2 (`pready` sampled), DONE and ready at N+3.
  - Each slave wait state adds one cycle.
- Requester handshake: keep `req` high until ready is seen, then drop it on the next edge. The arbiter is back in IDLE at N+4 and samples requests again there.
- Back-to-back: a new grant can occur in the IDLE cycle immediately after DONE. Minimum transfer period is 4 cycles.
- Timeout with `TIMEOUT`=T: ACCESS lasts exactly T cycles, then DONE. `pready` arriving in the T-th cycle completes normally with no timeout.
- The wait counter is wide enough for `TIMEOUT` and clears on entry to SETUP.

## Test plan
- **Fetch read, zero-wait**: `if_req`, `if_addr`=0x0000_0100, `prdata`=0x0000_0013.
  - Expect `psel` at N+1, `penable` at N+2, `if_ready`=1 at N+3 with `if_rdata`=0x13, `if_err`=0.
  - `pstrb`=0, `pwrite`=0.
- **Data write with 2 wait states**: `d_we`=1, `d_addr`=0x2000_0004, `d_wdata`=0xDEAD_BEEF, `d_be`=0b0011.
  - Expect `pwrite`=1, `pstrb`=0b0011 stable for 3 ACCESS cycles, then `d_ready` one cycle later.
- **Simultaneous requests**: `if_req` and `d_req` asserted together from reset, all held.
  - Grants alternate data, fetch, data; `owner` reads 1, 0, 1 across transfers; neither port starves.
- **Slave error**: data read with `pslverr`=1 at `pready`.
  - Expect `d_err`=1, `d_rdata`=0; the next clean read clears `d_err`.
- **Timeout**: `TIMEOUT`=4, `pready` held at 0.
  - Expect exactly 4 ACCESS cycles, then `if_ready`=1 with `if_err`=1, `if_rdata`=0; a following transfer succeeds.
- **Reset mid-ACCESS**: assert `rst` during a wait-stated transfer.
  - Next cycle: state IDLE, all outputs 0, no ready pulse; after release, a fresh request completes normally.

Source files
------------

// File: rtl/apb_mem_arbiter.sv
// Two-port round-robin arbiter and APB master shared by instruction fetch and load/store.
// Serialises held requests into SETUP/ACCESS transfers with a ready timeout and error return.
module apb_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ready,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr,
    output logic                busy,
    output logic                owner
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN  = (TIMEOUT != 0);
    // Counter holds the number of ACCESS cycles already elapsed, so the last allowed one is TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q,      state_d;
    logic                last_owner_q, last_owner_d;
    logic                owner_q,      owner_d;
    logic                psel_q,       psel_d;
    logic                penable_q,    penable_d;
    logic                pwrite_q,     pwrite_d;
    logic [ADDR_W-1:0]   paddr_q,      paddr_d;
    logic [DATA_W-1:0]   pwdata_q,     pwdata_d;
    logic [STRB_W-1:0]   pstrb_q,      pstrb_d;
    logic [CNT_W-1:0]    wait_cnt_q,   wait_cnt_d;
    logic                if_ready_q,   if_ready_d;
    logic [DATA_W-1:0]   if_rdata_q,   if_rdata_d;
    logic                if_err_q,     if_err_d;
    logic                d_ready_q,    d_ready_d;
    logic [DATA_W-1:0]   d_rdata_q,    d_rdata_d;
    logic                d_err_q,      d_err_d;

    logic                grant;
    logic                finish;
    logic                fin_err;
    logic [DATA_W-1:0]   fin_rdata;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        wait_cnt_d   = wait_cnt_q;
        if_ready_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        if_err_d     = if_err_q;
        d_ready_d    = 1'b0;
        d_rdata_d    = d_rdata_q;
        d_err_d      = d_err_q;
        grant        = 1'b0;
        finish       = 1'b0;
        fin_err      = 1'b0;
        fin_rdata    = '0;

        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    // On a tie the port that did not go last wins.
                    grant      = (if_req && d_req) ? ~last_owner_q : d_req;
                    owner_d    = grant;
                    paddr_d    = grant ? d_addr : if_addr;
                    pwrite_d   = grant & d_we;
                    pwdata_d   = grant ? d_wdata : '0;
                    pstrb_d    = (grant && d_we) ? d_be : '0;
                    wait_cnt_d = '0;
                    psel_d     = 1'b1;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (pready) begin
                    finish    = 1'b1;
                    fin_err   = pslverr;
                    fin_rdata = pslverr ? '0 : prdata;
                end else if (TO_EN && (wait_cnt_q == CNT_LAST)) begin
                    finish    = 1'b1;
                    fin_err   = 1'b1;
                end
                if (finish) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    state_d   = S_DONE;
                    if (owner_q) begin
                        d_ready_d  = 1'b1;
                        d_rdata_d  = fin_rdata;
                        d_err_d    = fin_err;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = fin_rdata;
                        if_err_d   = fin_err;
                    end
                end
            end
            S_DONE: begin
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_owner_q <= 1'b0;
            owner_q      <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            wait_cnt_q   <= '0;
            if_ready_q   <= 1'b0;
            if_rdata_q   <= '0;
            if_err_q     <= 1'b0;
            d_ready_q    <= 1'b0;
            d_rdata_q    <= '0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            wait_cnt_q   <= wait_cnt_d;
            if_ready_q   <= if_ready_d;
            if_rdata_q   <= if_rdata_d;
            if_err_q     <= if_err_d;
            d_ready_q    <= d_ready_d;
            d_rdata_q    <= d_rdata_d;
            d_err_q      <= d_err_d;
        end
    end

    assign psel     = psel_q;
    assign penable  = penable_q;
    assign pwrite   = pwrite_q;
    assign paddr    = paddr_q;
    assign pwdata   = pwdata_q;
    assign pstrb    = pstrb_q;
    assign if_ready = if_ready_q;
    assign if_rdata = if_rdata_q;
    assign if_err   = if_err_q;
    assign d_ready  = d_ready_q;
    assign d_rdata  = d_rdata_q;
    assign d_err    = d_err_q;
    assign busy     = (state_q != S_IDLE);
    assign owner    = owner_q;

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Scoreboard bench for apb_mem_arbiter: stimulus queues expected APB transfers and completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_apb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [SW-1:0] d_be = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;
    logic          busy;
    logic          owner;

    always #5 clk = ~clk;

    apb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .busy(busy), .owner(owner)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
    } apb_t;

    typedef struct {
        logic          port;
        logic [DW-1:0] rdata;
        logic          err;
        int            acc;
    } rsp_t;

    apb_t apb_q[$];
    rsp_t rsp_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave model: answers after slv_wait extra ACCESS cycles, or never when slv_hang.
    logic [DW-1:0] slv_rdata = '0;
    logic          slv_err = 1'b0;
    int            slv_wait = 0;
    logic          slv_hang = 1'b0;
    int            slv_cnt = 0;

    always @(negedge clk) begin
        if (psel && penable) begin
            pready  = !slv_hang && (slv_cnt == slv_wait);
            pslverr = pready && slv_err;
            prdata  = pready ? slv_rdata : 32'hBAD0_BAD0;
            slv_cnt++;
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = 32'hBAD0_BAD0;
            slv_cnt = 0;
        end
    end

    // Monitor
    apb_t cur;
    rsp_t r;
    int   acc_n = 0;

    always @(negedge clk) begin
        if (rst) begin
            acc_n = 0;
        end else begin
            chk("busy", {63'd0, busy}, {63'd0, psel | if_ready | d_ready});
            if (psel && !penable) begin
                acc_n = 0;
                if (apb_q.size() == 0) begin
                    chk("unexpected_setup", 64'd1, 64'd0);
                end else begin
                    cur = apb_q.pop_front();
                    chk("setup_paddr",  {32'd0, paddr},  {32'd0, cur.addr});
                    chk("setup_pwrite", {63'd0, pwrite}, {63'd0, cur.wr});
                    chk("setup_pwdata", {32'd0, pwdata}, {32'd0, cur.wdata});
                    chk("setup_pstrb",  {60'd0, pstrb},  {60'd0, cur.strb});
                end
            end
            if (psel && penable) begin
                acc_n++;
                chk("access_paddr",  {32'd0, paddr},  {32'd0, cur.addr});
                chk("access_pwrite", {63'd0, pwrite}, {63'd0, cur.wr});
                chk("access_pstrb",  {60'd0, pstrb},  {60'd0, cur.strb});
            end
            if (if_ready && d_ready) chk("both_ready", 64'd1, 64'd0);
            if (if_ready || d_ready) begin
                chk("done_psel", {63'd0, psel | penable}, 64'd0);
                if (rsp_q.size() == 0) begin
                    chk("unexpected_ready", 64'd1, 64'd0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("ready_port", {63'd0, d_ready}, {63'd0, r.port});
                    chk("owner", {63'd0, owner}, {63'd0, r.port});
                    chk("rdata", {32'd0, (r.port ? d_rdata : if_rdata)}, {32'd0, r.rdata});
                    chk("err", {63'd0, (r.port ? d_err : if_err)}, {63'd0, r.err});
                    chk("access_cycles", 64'(acc_n), 64'(r.acc));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_psel"},    {63'd0, psel},    64'd0);
        chk({tag, "_penable"}, {63'd0, penable}, 64'd0);
        chk({tag, "_pwrite"},  {63'd0, pwrite},  64'd0);
        chk({tag, "_paddr"},   {32'd0, paddr},   64'd0);
        chk({tag, "_pwdata"},  {32'd0, pwdata},  64'd0);
        chk({tag, "_pstrb"},   {60'd0, pstrb},   64'd0);
        chk({tag, "_busy"},    {63'd0, busy},    64'd0);
        chk({tag, "_owner"},   {63'd0, owner},   64'd0);
        chk({tag, "_ready"},   {62'd0, if_ready, d_ready}, 64'd0);
        chk({tag, "_if_rdata"}, {32'd0, if_rdata}, 64'd0);
        chk({tag, "_d_rdata"},  {32'd0, d_rdata},  64'd0);
        chk({tag, "_errs"},    {62'd0, if_err, d_err}, 64'd0);
    endtask

    task automatic xfer(input logic port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [SW-1:0] be, input logic [DW-1:0] rd,
                        input logic serr, input int waits, input logic hang);
        apb_t a;
        rsp_t e;
        int   lat;
        bit   seen;
        slv_rdata = rd; slv_err = serr; slv_wait = waits; slv_hang = hang;
        a.addr  = addr;
        a.wr    = port & we;
        a.wdata = port ? wdata : '0;
        a.strb  = (port && we) ? be : '0;
        apb_q.push_back(a);
        e.port  = port;
        e.rdata = (serr || hang) ? '0 : rd;
        e.err   = serr | hang;
        e.acc   = hang ? TO : waits + 1;
        rsp_q.push_back(e);
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        seen = 1'b0;
        lat = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (i == 0) begin
                // Granted now; later changes must not leak onto the bus.
                d_we = ~we; d_addr = ~addr; d_wdata = ~wdata; d_be = ~be; if_addr = ~addr;
            end
            seen = port ? d_ready : if_ready;
        end
        chk("latency", 64'(lat), 64'(hang ? 2 + TO : 3 + waits));
        @(posedge clk);
        #1;
        if_req = 1'b0;
        d_req = 1'b0;
    endtask

    int n;

    initial begin
        cyc(3);
        check_zero("reset");
        rst = 1'b0;
        cyc(1);

        // Tie from reset: data, fetch, data.
        slv_rdata = 32'h55; slv_err = 1'b0; slv_wait = 0; slv_hang = 1'b0;
        apb_q.push_back('{32'h3000_0000, 1'b1, 32'h1111_2222, 4'hF});
        apb_q.push_back('{32'h0000_0200, 1'b0, 32'h0, 4'h0});
        apb_q.push_back('{32'h3000_0000, 1'b1, 32'h1111_2222, 4'hF});
        rsp_q.push_back('{1'b1, 32'h55, 1'b0, 1});
        rsp_q.push_back('{1'b0, 32'h55, 1'b0, 1});
        rsp_q.push_back('{1'b1, 32'h55, 1'b0, 1});
        if_req = 1'b1; if_addr = 32'h0000_0200;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000_0000; d_wdata = 32'h1111_2222; d_be = 4'hF;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(posedge clk);
            #1;
            if (if_ready || d_ready) n++;
        end
        chk("tie_transfers", 64'(n), 64'd3);
        @(posedge clk);
        #1;
        if_req = 1'b0; d_req = 1'b0;
        cyc(2);

        xfer(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h0000_0013, 1'b0, 0, 1'b0);
        xfer(1'b1, 1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 4'b0011, 32'h0000_0777, 1'b0, 2, 1'b0);
        chk("if_rdata_hold", {32'd0, if_rdata}, 64'h13);

        xfer(1'b1, 1'b0, 32'h2000_0010, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b1, 1, 1'b0);
        cyc(2);
        chk("d_err_hold", {63'd0, d_err}, 64'd1);
        xfer(1'b1, 1'b0, 32'h2000_0014, 32'h0, 4'h0, 32'h0000_1234, 1'b0, 0, 1'b0);

        // pready in the last allowed ACCESS cycle is a normal completion.
        xfer(1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'hABCD_0001, 1'b0, TO - 1, 1'b0);
        xfer(1'b0, 1'b0, 32'h0000_0108, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, 0, 1'b1);
        xfer(1'b0, 1'b0, 32'h0000_010C, 32'h0, 4'h0, 32'h0000_0042, 1'b0, 0, 1'b0);

        // Reset during a stalled write: no completion may appear.
        slv_hang = 1'b1;
        apb_q.push_back('{32'h2000_0020, 1'b1, 32'h0BAD_F00D, 4'b1100});
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000_0020; d_wdata = 32'h0BAD_F00D; d_be = 4'b1100;
        cyc(4);
        chk("pre_reset_access", {62'd0, psel, penable}, 64'd3);
        rst = 1'b1;
        d_req = 1'b0;
        cyc(1);
        check_zero("midreset");
        rst = 1'b0;
        slv_hang = 1'b0;
        cyc(3);
        xfer(1'b0, 1'b0, 32'h0000_0110, 32'h0, 4'h0, 32'h0000_5A5A, 1'b0, 1, 1'b0);

        cyc(3);
        chk("apb_q_empty", 64'(apb_q.size()), 64'd0);
        chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
